// File: rtl/ret_addr_stack_pkg.sv
// ---------------------------------------------------------------------------
// ret_addr_stack_pkg
//   Shared processor constants and helpers for the return-address stack.
//   PC_W is the program-counter width. The stack defaults (address width and
//   entry count) live beside it so the PC block and the stack stay in step.
//   ras_decode() collapses the push/pop/clear inputs into a single operation
//   code, so the stack's next-state logic reads as a case over operations.
// ---------------------------------------------------------------------------
package ret_addr_stack_pkg;

    localparam int PC_W      = 12;
    localparam int RAS_D     = PC_W;
    localparam int RAS_DEPTH = 4;

    typedef enum logic [2:0] {
        OP_NONE    = 3'd0,
        OP_PUSH    = 3'd1,
        OP_POP     = 3'd2,
        OP_REPLACE = 3'd3,
        OP_CLEAR   = 3'd4
    } ras_op_e;

    // Clear wins over everything else. Push and pop together on a non-empty
    // stack replace the top entry. On an empty stack there is nothing to
    // replace, so it degrades to a plain push and the pop is ignored
    // (underflow is not set).
    function automatic ras_op_e ras_decode(input logic clr,
                                           input logic psh,
                                           input logic pp,
                                           input logic is_empty);
        ras_op_e op;
        if (clr)                      op = OP_CLEAR;
        else if (psh && pp && !is_empty) op = OP_REPLACE;
        else if (psh)                 op = OP_PUSH;
        else if (pp)                  op = OP_POP;
        else                          op = OP_NONE;
        return op;
    endfunction

endpackage

// File: rtl/ret_addr_stack_if.sv
// ---------------------------------------------------------------------------
// ret_addr_stack_if
//   Bundles the control inputs and status outputs of the return-address stack.
//   Command side (master drives, slave receives):
//     push, push_addr  call taken; link address to save
//     pop              return instruction executing
//     clear            synchronous flush of all entries
//   Status side (slave drives, master receives):
//     top              current top-of-stack address (0 when empty)
//     empty, full      count == 0 / count == DEPTH
//     count            number of valid entries
//     overflow         sticky: a push arrived while the stack was full
//     underflow        sticky: a pop arrived while the stack was empty
// ---------------------------------------------------------------------------
interface ret_addr_stack_if
    import ret_addr_stack_pkg::*;
#(
    parameter int D     = RAS_D,
    parameter int DEPTH = RAS_DEPTH
);
    logic                       push;
    logic [D-1:0]               push_addr;
    logic                       pop;
    logic                       clear;
    logic [D-1:0]               top;
    logic                       empty;
    logic                       full;
    logic [$clog2(DEPTH):0]     count;
    logic                       overflow;
    logic                       underflow;

    modport master (
        output push, push_addr, pop, clear,
        input  top, empty, full, count, overflow, underflow
    );

    modport slave (
        input  push, push_addr, pop, clear,
        output top, empty, full, count, overflow, underflow
    );
endinterface

// File: rtl/ret_addr_stack.sv
// ---------------------------------------------------------------------------
// ret_addr_stack
//   Hardware return-address stack, implemented as a circular buffer of DEPTH
//   entries. wp points at the next free slot, so the top entry is mem[wp-1].
//   When the stack is full, a push overwrites the oldest entry, so the
//   newest DEPTH call sites are always kept. All status outputs are decoded
//   from registered state. Nothing from push or pop reaches top in the same
//   cycle.
//   Ports:
//     clk    sole clock, rising edge
//     reset  asynchronous, active-low
//     bus    ret_addr_stack_if.slave (commands in, status out)
// ---------------------------------------------------------------------------
module ret_addr_stack
    import ret_addr_stack_pkg::*;
#(
    parameter int D     = RAS_D,
    parameter int DEPTH = RAS_DEPTH
)(
    input  logic              clk,
    input  logic              reset,
    ret_addr_stack_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);

    logic [D-1:0]  mem_q [DEPTH];

    logic [AW-1:0] wp_q,  wp_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic          mem_we;
    logic [AW-1:0] mem_widx;
    logic [AW-1:0] wp_m1;
    logic          is_empty, is_full;
    ras_op_e       op;

    assign wp_m1    = wp_q - AW'(1);
    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == (AW+1)'(DEPTH));
    assign op       = ras_decode(bus.clear, bus.push, bus.pop, is_empty);

    always_comb begin
        wp_d        = wp_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        mem_we      = 1'b0;
        mem_widx    = wp_q;
        case (op)
            OP_CLEAR: begin
                wp_d        = '0;
                count_d     = '0;
                overflow_d  = 1'b0;
                underflow_d = 1'b0;
            end
            OP_PUSH: begin
                // When the stack is full, slot wp holds the oldest entry,
                // so writing there drops it and count stays at DEPTH.
                mem_we = 1'b1;
                wp_d   = wp_q + AW'(1);
                if (is_full) overflow_d = 1'b1;
                else         count_d    = count_q + (AW+1)'(1);
            end
            OP_POP: begin
                if (is_empty) begin
                    underflow_d = 1'b1;
                end else begin
                    wp_d    = wp_m1;
                    count_d = count_q - (AW+1)'(1);
                end
            end
            OP_REPLACE: begin
                mem_we   = 1'b1;
                mem_widx = wp_m1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp_q        <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wp_q        <= wp_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is not reset. Stale entries are hidden by the count==0 gate
    // on top, and they are always rewritten before they become visible again.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_widx] <= bus.push_addr;
    end

    assign bus.top       = is_empty ? '0 : mem_q[wp_m1];
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_ret_addr_stack.sv
module tb_ret_addr_stack;
    localparam int D     = 12;
    localparam int DEPTH = 4;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    ret_addr_stack_if #(.D(D), .DEPTH(DEPTH)) bus ();

    ret_addr_stack #(.D(D), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then return 1ns after the edge with inputs idle.
    task automatic step(input logic p, input logic [D-1:0] a, input logic q, input logic c);
        bus.push = p; bus.push_addr = a; bus.pop = q; bus.clear = c;
        @(posedge clk);
        #1;
        bus.push = 1'b0; bus.pop = 1'b0; bus.clear = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        bus.push = 0; bus.push_addr = '0; bus.pop = 0; bus.clear = 0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_top",   32'(bus.top), 32'h0);
        chk("rst_empty", 32'(bus.empty), 32'h1);
        chk("rst_full",  32'(bus.full), 32'h0);
        chk("rst_count", 32'(bus.count), 32'h0);
        chk("rst_ovf",   32'(bus.overflow), 32'h0);
        chk("rst_udf",   32'(bus.underflow), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        // Basic LIFO order
        step(1, 12'h005, 0, 0);
        step(1, 12'h0A3, 0, 0);
        step(1, 12'h101, 0, 0);
        chk("lifo_top3",   32'(bus.top), 32'h101);
        chk("lifo_count3", 32'(bus.count), 32'h3);
        step(0, 12'h0, 1, 0);
        chk("lifo_pop1", 32'(bus.top), 32'h0A3);
        step(0, 12'h0, 1, 0);
        chk("lifo_pop2", 32'(bus.top), 32'h005);
        step(0, 12'h0, 1, 0);
        chk("lifo_empty", 32'(bus.empty), 32'h1);
        chk("lifo_top0",  32'(bus.top), 32'h0);

        // Overflow: five pushes into four entries drop the oldest one
        for (int i = 1; i <= 5; i++) step(1, 12'(i), 0, 0);
        chk("ovf_full",  32'(bus.full), 32'h1);
        chk("ovf_flag",  32'(bus.overflow), 32'h1);
        chk("ovf_count", 32'(bus.count), 32'h4);
        chk("ovf_top",   32'(bus.top), 32'h005);
        step(0, 12'h0, 1, 0);
        chk("ovf_pop1", 32'(bus.top), 32'h004);
        step(0, 12'h0, 1, 0);
        chk("ovf_pop2", 32'(bus.top), 32'h003);
        step(0, 12'h0, 1, 0);
        chk("ovf_pop3", 32'(bus.top), 32'h002);
        chk("ovf_cnt1", 32'(bus.count), 32'h1);
        step(0, 12'h0, 1, 0);
        chk("ovf_empty",  32'(bus.empty), 32'h1);
        chk("ovf_sticky", 32'(bus.overflow), 32'h1);
        chk("ovf_noudf",  32'(bus.underflow), 32'h0);

        // Underflow, sticky behaviour, and clear
        step(0, 12'h0, 0, 1);
        chk("clr_ovf", 32'(bus.overflow), 32'h0);
        step(0, 12'h0, 1, 0);
        chk("udf_flag",  32'(bus.underflow), 32'h1);
        chk("udf_count", 32'(bus.count), 32'h0);
        step(1, 12'h020, 0, 0);
        chk("udf_top",    32'(bus.top), 32'h020);
        chk("udf_sticky", 32'(bus.underflow), 32'h1);
        step(1, 12'h033, 1, 1);  // clear beats push and pop
        chk("clr_udf",   32'(bus.underflow), 32'h0);
        chk("clr_ovf2",  32'(bus.overflow), 32'h0);
        chk("clr_empty", 32'(bus.empty), 32'h1);
        chk("clr_top",   32'(bus.top), 32'h0);

        // Simultaneous push+pop replaces the top entry
        step(1, 12'h030, 0, 0);
        step(1, 12'h040, 0, 0);
        chk("rep_pre_top", 32'(bus.top), 32'h040);
        step(1, 12'h077, 1, 0);
        chk("rep_top",   32'(bus.top), 32'h077);
        chk("rep_count", 32'(bus.count), 32'h2);
        step(0, 12'h0, 1, 0);
        chk("rep_below", 32'(bus.top), 32'h030);
        step(0, 12'h0, 1, 0);
        step(1, 12'h011, 1, 0);  // empty: push only
        chk("rep_e_count", 32'(bus.count), 32'h1);
        chk("rep_e_top",   32'(bus.top), 32'h011);
        chk("rep_e_udf",   32'(bus.underflow), 32'h0);

        // Asynchronous reset between edges while a push is pending
        step(0, 12'h0, 0, 1);
        step(1, 12'h0A1, 0, 0);
        step(1, 12'h0A2, 0, 0);
        step(1, 12'h0A3, 0, 0);
        chk("ar_pre_count", 32'(bus.count), 32'h3);
        bus.push = 1'b1; bus.push_addr = 12'h0A4;
        #2;
        reset = 1'b0;
        #1;
        chk("ar_count", 32'(bus.count), 32'h0);
        chk("ar_empty", 32'(bus.empty), 32'h1);
        chk("ar_top",   32'(bus.top), 32'h0);
        chk("ar_full",  32'(bus.full), 32'h0);
        bus.push = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        step(1, 12'h0FF, 0, 0);
        chk("ar_post_count", 32'(bus.count), 32'h1);
        chk("ar_post_top",   32'(bus.top), 32'h0FF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ret_addr_stack.md
RET_ADDR_STACK -- requirements
Module: ret_addr_stack

Interface
REQ-001 SHALL have parameter D, default 12: return-address width, equal to the program-counter width.
REQ-002 SHALL have parameter DEPTH, default 4: number of entries; a power of two, at least 2.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port push  input  1  call taken this cycle; qualified by the same condition as the PC jump enable.
REQ-006 SHALL have port push_addr  input  D  link address to save, taken from the PC block's prevAddr (jump address + 1).
REQ-007 SHALL have port pop  input  1  return instruction executing this cycle.
REQ-008 SHALL have port clear  input  1  synchronous flush of all entries.
REQ-009 SHALL have port top  output  D  current top-of-stack address; 0 when empty.
REQ-010 SHALL have port empty  output  1  count == 0.
REQ-011 SHALL have port full  output  1  count == DEPTH.
REQ-012 SHALL have port count  output  $clog2(DEPTH)+1  number of valid entries.
REQ-013 SHALL have port overflow  output  1  sticky flag: a push occurred while full.
REQ-014 SHALL have port underflow  output  1  sticky flag: a pop occurred while empty.

Function
REQ-015 SHALL implement storage as a circular buffer indexed by a write pointer wp, with wp modulo DEPTH.
REQ-016 SHALL make top combinational from registered state: mem[wp-1] when count>0, else 0.
REQ-017 SHALL make top, empty, full and count reflect any operation in the cycle after its edge; there is no same-cycle bypass.
REQ-018 SHALL, on push only with count<DEPTH: write mem[wp]=push_addr, increment wp, increment count.
REQ-019 SHALL, on push only when full: overwrite the oldest entry (mem[wp]), increment wp, hold count at DEPTH, and set overflow.
REQ-020 SHALL, on pop only with count>0: decrement wp and count; stored data is left unchanged.
REQ-021 SHALL, on pop only when empty: leave wp and count unchanged and set underflow.
REQ-022 SHALL, on simultaneous push and pop with count>0: write mem[wp-1]=push_addr (replace top), leaving wp, count and flags unchanged.
REQ-023 SHALL, on simultaneous push and pop when empty: perform the push only; underflow is not set.
REQ-024 SHALL make clear take priority over push and pop: wp=0, count=0, overflow=0, underflow=0.
REQ-025 SHALL hold overflow and underflow once set until clear or reset.
REQ-026 SHALL compute wrap-around of wp by natural width truncation; count never exceeds DEPTH and never goes below 0.
REQ-027 SHALL be fully synchronous apart from reset; there are no combinational paths from push or pop to top.

Reset
REQ-028 SHALL, on reset low and asynchronously: wp=0, count=0, overflow=0, underflow=0, so top=0, empty=1 and full=0.
REQ-029 SHALL leave stored entries uninitialised by reset; they are unobservable while empty.
REQ-030 SHALL abort an in-flight push or pop when reset is asserted mid-cycle; the first edge after deassertion operates normally.

Structure
REQ-031 SHALL place the default address width (12) and DEPTH (4) as constants in the shared processor package, next to the PC width.
REQ-032 SHALL be a single module with no sub-module; the storage is a flat register array inside it.

Verification
REQ-033 Reset, then push 0x005, 0x0A3, 0x101 -> top=0x101, count=3; pop -> top=0x0A3; pop -> top=0x005; pop -> empty=1, top=0.
REQ-034 Push five addresses 0x001..0x005 with DEPTH=4 -> full=1, overflow=1, count=4; four pops return 0x005, 0x004, 0x003, 0x002, then empty=1.
REQ-035 Pop when empty -> underflow=1, count=0; then push 0x020 -> top=0x020 with underflow still 1; clear -> all flags 0, empty=1.
REQ-036 With count=2 and top=0x040, push 0x077 and pop together -> top=0x077, count=2; when empty, push 0x011 and pop together -> count=1, top=0x011, underflow=0.
REQ-037 Assert reset asynchronously between edges while pushing at count=3 -> outputs go to reset values immediately without waiting for clk; after release, push 0x0FF -> count=1, top=0x0FF.
